// File: rtl/cic_decimator_if.sv
// Sample-stream bundle between the CIC decimator and its neighbours.
// The master drives the input strobe, sample and controls; the slave returns the decimated stream.
interface cic_decimator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         EN;
    logic                         bypass;
    logic [1:0]                   dec_sel;
    logic signed [DATA_WIDTH-1:0] x_n;
    logic signed [DATA_WIDTH-1:0] y_m;
    logic                         valid;

    modport master (
        output EN, bypass, dec_sel, x_n,
        input  y_m, valid
    );

    modport slave (
        input  EN, bypass, dec_sel, x_n,
        output y_m, valid
    );
endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with unity gain and run-time power-of-two rate R in {2,4,8,16}.
// Integrators run on every input strobe; the combs and the output register fire once per frame.
module cic_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 3
) (
    input  logic             CLK,
    input  logic             RST,
    cic_decimator_if.slave   bus
);
    localparam int W   = DATA_WIDTH + 4 * STAGES;
    localparam int SHW = $clog2(W);

    logic signed [W-1:0]          integ_q [STAGES];
    logic signed [W-1:0]          integ_d [STAGES];
    logic signed [W-1:0]          dly_q   [STAGES];
    logic signed [W-1:0]          dly_d   [STAGES];
    logic signed [W-1:0]          comb    [STAGES];
    logic [3:0]                   cnt_q, cnt_d;
    logic [1:0]                   dec_q, dec_d;
    logic signed [DATA_WIDTH-1:0] y_q, y_d;
    logic                         valid_q, valid_d;
    logic [3:0]                   last_cnt;
    logic [SHW-1:0]               shift;
    logic                         term;
    logic signed [W-1:0]          x_ext;

    assign x_ext = {{(W-DATA_WIDTH){bus.x_n[DATA_WIDTH-1]}}, bus.x_n};

    always_comb begin
        last_cnt = 4'd1;
        shift    = SHW'(STAGES);
        case (dec_q)
            2'd0: begin last_cnt = 4'd1;  shift = SHW'(STAGES);     end
            2'd1: begin last_cnt = 4'd3;  shift = SHW'(2 * STAGES); end
            2'd2: begin last_cnt = 4'd7;  shift = SHW'(3 * STAGES); end
            2'd3: begin last_cnt = 4'd15; shift = SHW'(4 * STAGES); end
            default: begin last_cnt = 4'd1; shift = SHW'(STAGES); end
        endcase
    end

    assign term = bus.EN && (cnt_q == last_cnt);

    always_comb begin
        for (int k = 0; k < STAGES; k++) comb[k] = '0;
        comb[0] = integ_q[STAGES-1] - dly_q[0];
        for (int k = 1; k < STAGES; k++) comb[k] = comb[k-1] - dly_q[k];
    end

    always_comb begin
        integ_d = integ_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        y_d     = y_q;
        valid_d = term;
        if (bus.EN) begin
            integ_d[0] = integ_q[0] + x_ext;
            for (int k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
            if (cnt_q == 4'd0) dec_d = bus.dec_sel;
            cnt_d = term ? 4'd0 : cnt_q + 4'd1;
        end
        if (term) begin
            dly_d[0] = integ_q[STAGES-1];
            for (int k = 1; k < STAGES; k++) dly_d[k] = comb[k-1];
            // shift + DATA_WIDTH never exceeds W, so this window is exactly the floor shift truncated
            y_d = comb[STAGES-1][shift +: DATA_WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            cnt_q   <= '0;
            dec_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign bus.y_m   = bus.bypass ? bus.x_n : y_q;
    assign bus.valid = bus.bypass ? bus.EN  : valid_q;
endmodule
